// File: rtl/pwm_slew_limiter_pkg.sv
// rtl/pwm_slew_limiter_pkg.sv - shared duty width, reset duty, slew states and step arithmetic
package pwm_slew_limiter_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] INIT_DUTY_DEF = 8'h80;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } slew_state_e;

  // One clamped step of cur toward tgt; 9-bit math so 0/255 never wrap.
  function automatic logic [DUTY_W-1:0] slew_step(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [3:0]        step
  );
    logic [DUTY_W:0] s;
    logic [DUTY_W:0] acc;
    s = (step == 4'd0) ? 9'd1 : {5'd0, step};
    if (cur < tgt) begin
      acc = {1'b0, cur} + s;
      return (acc >= {1'b0, tgt}) ? tgt : acc[DUTY_W-1:0];
    end else if (cur > tgt) begin
      acc = {1'b0, cur} - s;
      return ({1'b0, cur} <= s + {1'b0, tgt}) ? tgt : acc[DUTY_W-1:0];
    end
    return cur;
  endfunction

endpackage

// File: rtl/slew_ratediv.sv
// rtl/slew_ratediv.sv - PWM-period divider producing one stepen pulse every ratediv+1 ticks
module slew_ratediv #(
  parameter int RATE_DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cycletick,
  input  logic                  clear,
  input  logic [RATE_DIV_W-1:0] ratediv,
  output logic                  stepen
);

  logic [RATE_DIV_W-1:0] divcnt;

  // A shrunken ratediv below divcnt is reached again only after divcnt wraps.
  assign stepen = cycletick && !clear && (divcnt == ratediv);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      divcnt <= '0;
    end else if (stepen) begin
      divcnt <= '0;
    end else if (cycletick) begin
      divcnt <= divcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_slew_limiter.sv
// rtl/pwm_slew_limiter.sv - duty slew-rate limiter feeding the PWM holding register
// Optional SLEW_IMMEDIATE_EN adds an `immediate` input that bypasses slewing on a write.
module pwm_slew_limiter
  import pwm_slew_limiter_pkg::*;
#(
  parameter logic [DUTY_W-1:0] INIT_DUTY  = INIT_DUTY_DEF,
  parameter int                RATE_DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cycletick,
  input  logic                  tgtwe,
  input  logic [DUTY_W-1:0]     tgtdata,
  input  logic [3:0]            step,
  input  logic [RATE_DIV_W-1:0] ratediv,
`ifdef SLEW_IMMEDIATE_EN
  input  logic                  immediate,
`endif
  output logic                  pwmldce,
  output logic [DUTY_W-1:0]     wrtdata,
  output logic                  busy
);

  slew_state_e       state_q, state_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              ld_d;
  logic              imm_wr;
  logic              div_clear;
  logic              stepen;

`ifdef SLEW_IMMEDIATE_EN
  assign imm_wr = tgtwe && immediate;
`else
  assign imm_wr = 1'b0;
`endif

  // The divider only runs while a ramp is genuinely outstanding.
  assign div_clear = (state_q == IDLE) || (cur_q == target_q) || imm_wr;

  slew_ratediv #(
    .RATE_DIV_W(RATE_DIV_W)
  ) u_ratediv (
    .clk      (clk),
    .reset    (reset),
    .cycletick(cycletick),
    .clear    (div_clear),
    .ratediv  (ratediv),
    .stepen   (stepen)
  );

  always_comb begin
    cur_d    = cur_q;
    target_d = target_q;
    state_d  = state_q;
    if (stepen) begin
      cur_d = slew_step(cur_q, target_q, step);
    end
    // Transitions compare against the old target; a fresh write is seen next edge.
    case (state_q)
      IDLE:    if (cur_q != target_q) state_d = WAIT;
      WAIT:    if (cur_d == target_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tgtwe) begin
      target_d = tgtdata;
    end
    if (imm_wr) begin
      cur_d   = tgtdata;
      state_d = IDLE;
    end
    ld_d = (cur_d != cur_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= INIT_DUTY;
      target_q <= INIT_DUTY;
      pwmldce  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      pwmldce  <= ld_d;
    end
  end

  assign wrtdata = cur_q;
  assign busy    = (state_q == WAIT);

endmodule

// File: tb/tb_pwm_slew_limiter.sv
// tb/tb_pwm_slew_limiter.sv - directed bench with a per-cycle behavioural model of the slew limiter
module tb_pwm_slew_limiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cycletick = 1'b0;
  logic       tgtwe = 1'b0;
  logic [7:0] tgtdata = 8'h00;
  logic [3:0] step = 4'd1;
  logic [7:0] ratediv = 8'd0;
`ifdef SLEW_IMMEDIATE_EN
  logic       immediate = 1'b0;
`endif
  logic       pwmldce;
  logic [7:0] wrtdata;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ld_log[$];

  int m_cur = 128;
  int m_tgt = 128;
  int m_div = 0;
  bit m_busy = 0;
  bit m_ld = 0;

  pwm_slew_limiter dut (
    .clk      (clk),
    .reset    (reset),
    .cycletick(cycletick),
    .tgtwe    (tgtwe),
    .tgtdata  (tgtdata),
    .step     (step),
    .ratediv  (ratediv),
`ifdef SLEW_IMMEDIATE_EN
    .immediate(immediate),
`endif
    .pwmldce  (pwmldce),
    .wrtdata  (wrtdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model: the duty moves toward the target in clamped steps on every (ratediv+1)-th
  // PWM tick counted while a ramp is outstanding; busy means "not yet at the target".
  always begin
    @(posedge clk);
    if (reset) begin
      m_cur = 128; m_tgt = 128; m_div = 0; m_busy = 0; m_ld = 0;
    end else begin
      int s;
      int nc;
      s  = (step == 0) ? 1 : int'(step);
      nc = m_cur;
      if (m_busy && m_cur != m_tgt) begin
        if (cycletick) begin
          if (m_div == int'(ratediv)) begin
            nc    = (m_cur < m_tgt) ? ((m_cur + s > m_tgt) ? m_tgt : m_cur + s)
                                    : ((m_cur - s < m_tgt) ? m_tgt : m_cur - s);
            m_div = 0;
          end else begin
            m_div = (m_div + 1) % 256;
          end
        end
      end else begin
        m_div = 0;
      end
      m_busy = (nc != m_tgt);
`ifdef SLEW_IMMEDIATE_EN
      if (tgtwe && immediate) begin
        nc = int'(tgtdata); m_busy = 0; m_div = 0;
      end
`endif
      if (tgtwe) m_tgt = int'(tgtdata);
      m_ld  = (nc != m_cur);
      m_cur = nc;
    end
    #1;
    chk("wrtdata", int'(wrtdata), m_cur);
    chk("pwmldce", int'(pwmldce), int'(m_ld));
    chk("busy", int'(busy), int'(m_busy));
    if (pwmldce) ld_log.push_back(wrtdata);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) cycletick = 1'b1;
    @(negedge clk) cycletick = 1'b0;
    idle(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [7:0] v);
    @(negedge clk) begin tgtwe = 1'b1; tgtdata = v; end
    @(negedge clk) tgtwe = 1'b0;
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk) begin reset = 1'b1; tgtwe = 1'b0; cycletick = 1'b0; end
    idle(2);
    reset = 1'b0;
    idle(1);
    ld_log.delete();
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(6);
    chk("reset_wrtdata", int'(wrtdata), 8'h80);
    chk("reset_busy", int'(busy), 0);
    chk("reset_no_strobe", ld_log.size(), 0);

    // step 4, ratediv 0: four strobes 84/88/8C/90
    step = 4'd4; ratediv = 8'd0;
    write(8'h90);
    ticks(4);
    chk("ramp_n", ld_log.size(), 4);
    chk("ramp0", int'(ld_log[0]), 8'h84);
    chk("ramp1", int'(ld_log[1]), 8'h88);
    chk("ramp2", int'(ld_log[2]), 8'h8C);
    chk("ramp3", int'(ld_log[3]), 8'h90);
    chk("ramp_busy", int'(busy), 0);

    // step 5, ratediv 2: single clamped step on 3rd tick
    do_reset();
    step = 4'd5; ratediv = 8'd2;
    write(8'h7E);
    ticks(2);
    chk("div2_early", ld_log.size(), 0);
    tick();
    chk("div2_n", ld_log.size(), 1);
    chk("div2_val", int'(ld_log[0]), 8'h7E);

    // floor and ceiling without wrap
    do_reset();
    step = 4'd15; ratediv = 8'd0;
    write(8'h05);
    ticks(9);
    chk("to05", int'(wrtdata), 8'h05);
    ld_log.delete();
    write(8'h00);
    tick();
    chk("floor_n", ld_log.size(), 1);
    chk("floor", int'(ld_log[0]), 8'h00);
    write(8'hFE);
    ticks(17);
    chk("toFE", int'(wrtdata), 8'hFE);
    ld_log.delete();
    step = 4'd0;
    write(8'hFF);
    ticks(2);
    chk("ceil_n", ld_log.size(), 1);
    chk("ceil", int'(ld_log[0]), 8'hFF);

    // retarget mid-ramp keeps divider cadence
    do_reset();
    step = 4'd8; ratediv = 8'd1;
    write(8'hA0);
    ticks(5);
    chk("pre_retgt", int'(wrtdata), 8'h90);
    write(8'h70);
    tick();
    chk("retgt_n", ld_log.size(), 3);
    chk("retgt_dn", int'(ld_log[2]), 8'h88);
    ticks(6);
    chk("retgt_end", int'(wrtdata), 8'h70);

    // target written equal to cur ends the ramp
    do_reset();
    step = 4'd8; ratediv = 8'd0;
    write(8'h90);
    tick();
    write(8'h88);
    ticks(3);
    chk("eq_busy", int'(busy), 0);
    chk("eq_n", ld_log.size(), 1);

    // target write on the stepping edge
    do_reset();
    step = 4'd4; ratediv = 8'd0;
    write(8'h90);
    tick();
    @(negedge clk) begin cycletick = 1'b1; tgtwe = 1'b1; tgtdata = 8'h70; end
    @(negedge clk) begin cycletick = 1'b0; tgtwe = 1'b0; end
    idle(2);
    tick();
    chk("same_n", ld_log.size(), 3);
    chk("same_old", int'(ld_log[1]), 8'h88);
    chk("same_new", int'(ld_log[2]), 8'h84);

    // reset mid-ramp: back to 0x80 without a strobe
    do_reset();
    write(8'h20);
    ticks(2);
    @(negedge clk) reset = 1'b1;
    idle(2);
    chk("rst_mid_val", int'(wrtdata), 8'h80);
    reset = 1'b0;
    idle(4);
    chk("rst_mid_n", ld_log.size(), 2);
    chk("rst_mid_busy", int'(busy), 0);

`ifdef SLEW_IMMEDIATE_EN
    do_reset();
    step = 4'd4; ratediv = 8'd0;
    write(8'h90);
    tick();
    @(negedge clk) begin tgtwe = 1'b1; immediate = 1'b1; tgtdata = 8'h20; end
    @(negedge clk) begin tgtwe = 1'b0; immediate = 1'b0; end
    idle(3);
    chk("imm_n", ld_log.size(), 2);
    chk("imm_val", int'(wrtdata), 8'h20);
    chk("imm_busy", int'(busy), 0);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
